// File: rtl/regbank_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : regbank_pkg
//  Description : Shared widths, index/data types and helpers for regbank.
//  Revision    : 1.0 - initial release
// ============================================================================
package regbank_pkg;

  localparam int DATA_W   = 16;
  localparam int ADDR_W   = 3;
  localparam int NUM_REGS = 8;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] data_t;

  localparam reg_idx_t ZERO_IDX = 3'd0;

  // One-hot of idx, gated by en.
  function automatic logic [NUM_REGS-1:0] idx_onehot(input reg_idx_t idx, input logic en);
    logic [NUM_REGS-1:0] v;
    v      = '0;
    v[idx] = en;
    return v;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regbank_scoreboard_bit.sv
`default_nettype none
// ============================================================================
//  Module      : regbank_scoreboard_bit
//  Description : One pending-write flag; set has priority over clear.
//  Revision    : 1.0 - initial release
// ============================================================================
module regbank_scoreboard_bit (
  input  logic clk,
  input  logic rst_n,
  input  logic i_set,
  input  logic i_clr,
  output logic o_pend
);

  logic r_pend;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pend <= 1'b0;
    end else if (i_set) begin
      r_pend <= 1'b1;
    end else if (i_clr) begin
      r_pend <= 1'b0;
    end
  end

  assign o_pend = r_pend;

endmodule
`default_nettype wire

// File: rtl/regbank_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : regbank_scoreboard
//  Description : 8 x 16-bit register bank with write-back port and
//                pending-write scoreboard that stalls hazardous issues.
//                Optional macro REGBANK_ZERO_REG_EN hardwires R0 to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module regbank_scoreboard
  import regbank_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              issue_en,
  input  logic [ADDR_W-1:0] issue_dst,
  input  logic [ADDR_W-1:0] issue_src0,
  input  logic [ADDR_W-1:0] issue_src1,
  input  logic [ADDR_W-1:0] issue_src2,
  output logic              stall,
  output logic              issue_ack,
  output logic [DATA_W-1:0] r7_q,
  output logic [DATA_W-1:0] r6_q,
  output logic [DATA_W-1:0] r5_q,
  output logic [DATA_W-1:0] r4_q,
  output logic [DATA_W-1:0] r3_q,
  output logic [DATA_W-1:0] r2_q,
  output logic [DATA_W-1:0] r1_q,
  output logic [DATA_W-1:0] r0_q,
  output logic [NUM_REGS-1:0] pending
);

  data_t               r_regs [NUM_REGS];
  logic                w_stall;
  logic                w_wr_en;
  logic [NUM_REGS-1:0] w_set;
  logic [NUM_REGS-1:0] w_clr;

  // A same-cycle write-back does not unblock: its data is visible next cycle.
  assign w_stall   = issue_en & (pending[issue_src0] | pending[issue_src1] |
                                 pending[issue_src2] | pending[issue_dst]);
  assign stall     = w_stall;
  assign issue_ack = issue_en & ~w_stall;

`ifdef REGBANK_ZERO_REG_EN
  assign w_wr_en = wr_en & (wr_addr != ZERO_IDX);
  assign w_set   = idx_onehot(issue_dst, issue_ack) & ~idx_onehot(ZERO_IDX, 1'b1);
`else
  assign w_wr_en = wr_en;
  assign w_set   = idx_onehot(issue_dst, issue_ack);
`endif
  assign w_clr = idx_onehot(wr_addr, w_wr_en);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_regs[wr_addr] <= wr_data;
    end
  end

  for (genvar gi = 0; gi < NUM_REGS; gi++) begin : g_sb
    regbank_scoreboard_bit u_bit (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_set  (w_set[gi]),
      .i_clr  (w_clr[gi]),
      .o_pend (pending[gi])
    );
  end

  assign r7_q = r_regs[7];
  assign r6_q = r_regs[6];
  assign r5_q = r_regs[5];
  assign r4_q = r_regs[4];
  assign r3_q = r_regs[3];
  assign r2_q = r_regs[2];
  assign r1_q = r_regs[1];
  assign r0_q = r_regs[0];

endmodule
`default_nettype wire

// File: tb/tb_regbank_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : tb_regbank_scoreboard
//  Description : Directed scoreboard bench for regbank_scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_regbank_scoreboard;

`ifdef REGBANK_ZERO_REG_EN
  localparam bit ZERO_MODE = 1'b1;
`else
  localparam bit ZERO_MODE = 1'b0;
`endif

  typedef struct packed {
    logic [7:0]       pend;
    logic [7:0][15:0] regs;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [2:0]  wr_addr;
  logic [15:0] wr_data;
  logic        issue_en;
  logic [2:0]  issue_dst, issue_src0, issue_src1, issue_src2;
  logic        stall, issue_ack;
  logic [15:0] r7_q, r6_q, r5_q, r4_q, r3_q, r2_q, r1_q, r0_q;
  logic [7:0]  pending;
  logic [15:0] obs_r [8];

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]       m_pend;
  logic [7:0][15:0] m_regs;
  exp_t             exp_q[$];

  always #5 clk = ~clk;

  regbank_scoreboard dut (
    .clk(clk), .rst_n(rst_n),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_dst(issue_dst),
    .issue_src0(issue_src0), .issue_src1(issue_src1), .issue_src2(issue_src2),
    .stall(stall), .issue_ack(issue_ack),
    .r7_q(r7_q), .r6_q(r6_q), .r5_q(r5_q), .r4_q(r4_q),
    .r3_q(r3_q), .r2_q(r2_q), .r1_q(r1_q), .r0_q(r0_q),
    .pending(pending)
  );

  assign obs_r[7] = r7_q;
  assign obs_r[6] = r6_q;
  assign obs_r[5] = r5_q;
  assign obs_r[4] = r4_q;
  assign obs_r[3] = r3_q;
  assign obs_r[2] = r2_q;
  assign obs_r[1] = r1_q;
  assign obs_r[0] = r0_q;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic check_regs(input string tag, input logic [7:0][15:0] er);
    for (int i = 0; i < 8; i++) begin
      chk($sformatf("%s:r%0d", tag, i), obs_r[i], er[i]);
    end
  endtask

  // Drives one cycle, checks combinational outputs, then the post-edge state.
  task automatic step(input string tag, input logic we, input logic [2:0] wa,
                      input logic [15:0] wd, input logic ie, input logic [2:0] dst,
                      input logic [2:0] s0, input logic [2:0] s1, input logic [2:0] s2);
    exp_t       e;
    logic       es, ea;
    logic [7:0] np;
    wr_en = we; wr_addr = wa; wr_data = wd;
    issue_en = ie; issue_dst = dst;
    issue_src0 = s0; issue_src1 = s1; issue_src2 = s2;
    #1;
    es = ie & (m_pend[s0] | m_pend[s1] | m_pend[s2] | m_pend[dst]);
    ea = ie & ~es;
    chk({tag, ":stall"}, 16'(stall), 16'(es));
    chk({tag, ":ack"}, 16'(issue_ack), 16'(ea));
    np = m_pend;
    for (int i = 0; i < 8; i++) begin
      if (ea && dst == 3'(i) && !(ZERO_MODE && i == 0)) np[i] = 1'b1;
      else if (we && wa == 3'(i)) np[i] = 1'b0;
    end
    if (we && !(ZERO_MODE && wa == 3'd0)) m_regs[wa] = wd;
    m_pend = np;
    e.pend = np;
    e.regs = m_regs;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    chk({tag, ":pend"}, 16'(pending), 16'(e.pend));
    check_regs(tag, e.regs);
    @(negedge clk);
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    issue_en = 1'b0; issue_dst = '0;
    issue_src0 = '0; issue_src1 = '0; issue_src2 = '0;
    m_pend = '0;
    m_regs = '0;
    #12;
    chk("rst:pend", 16'(pending), 16'h0000);
    chk("rst:stall", 16'(stall), 16'h0000);
    chk("rst:ack", 16'(issue_ack), 16'h0000);
    check_regs("rst", '0);
    @(negedge clk);
    rst_n = 1'b1;

    step("wr5", 1'b1, 3'd5, 16'hBEEF, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    chk("wr5:const", r5_q, 16'hBEEF);

    step("iss3", 1'b0, 3'd0, 16'h0, 1'b1, 3'd3, 3'd0, 3'd1, 3'd2);
    chk("iss3:const", 16'(pending), 16'h0008);
    step("raw3", 1'b1, 3'd3, 16'h1234, 1'b1, 3'd4, 3'd3, 3'd1, 3'd2);
    chk("raw3:pend_const", 16'(pending), 16'h0000);
    chk("raw3:r3_const", r3_q, 16'h1234);
    step("retry", 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 3'd3, 3'd3, 3'd3);
    step("wb4", 1'b1, 3'd4, 16'hA4A4, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);

    // WAW hazard, then set-beats-clear on a simultaneous write-back and issue.
    step("iss2", 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd1, 3'd1, 3'd1);
    step("waw2", 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd1, 3'd6, 3'd7);
    step("wb2s", 1'b1, 3'd2, 16'h2222, 1'b1, 3'd2, 3'd1, 3'd1, 3'd1);
    step("setw", 1'b1, 3'd2, 16'h3333, 1'b1, 3'd2, 3'd1, 3'd1, 3'd1);
    chk("setw:const", 16'(pending[2]), 16'h0001);
    step("wb2", 1'b1, 3'd2, 16'h4444, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);

    step("wr7", 1'b1, 3'd7, 16'hFFFF, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    step("a0", 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd1, 3'd1, 3'd1);
    step("a2", 1'b0, 3'd0, 16'h0, 1'b1, 3'd2, 3'd1, 3'd1, 3'd1);
    step("a5", 1'b0, 3'd0, 16'h0, 1'b1, 3'd5, 3'd1, 3'd1, 3'd1);
    step("a7", 1'b0, 3'd0, 16'h0, 1'b1, 3'd7, 3'd1, 3'd1, 3'd1);
    if (!ZERO_MODE) chk("a5:const", 16'(pending), 16'h00A5);

    // Asynchronous reset between clock edges.
    wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h6666;
    issue_en = 1'b1; issue_dst = 3'd6;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst:pend", 16'(pending), 16'h0000);
    chk("arst:r7", r7_q, 16'h0000);
    chk("arst:stall", 16'(stall), 16'h0000);
    m_pend = '0;
    m_regs = '0;
    check_regs("arst", m_regs);
    wr_en = 1'b0; issue_en = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    step("z_wr", 1'b1, 3'd0, 16'h5555, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);
    step("z_iss", 1'b0, 3'd0, 16'h0, 1'b1, 3'd0, 3'd1, 3'd2, 3'd3);
    step("z_src", 1'b0, 3'd0, 16'h0, 1'b1, 3'd4, 3'd0, 3'd0, 3'd0);
    step("z_wb", 1'b1, 3'd0, 16'h7777, 1'b0, 3'd0, 3'd0, 3'd0, 3'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
